// File: rtl/qr_iteration_controller_if.sv
// Engine-side bus of the QR iteration controller: the QR decomposition block and the
// R*Q multiplier datapath. The controller is the master, the engines are the slave side.
interface qr_iteration_controller_if;
    logic         qr_start;
    logic [255:0] qr_a;
    logic         qr_done;
    logic [255:0] qr_q;
    logic [255:0] qr_r;
    logic         mult_enable;
    logic [255:0] mult_r;
    logic [255:0] mult_q;
    logic [255:0] mult_a_new;

    modport master (
        output qr_start, qr_a, mult_enable, mult_r, mult_q,
        input  qr_done, qr_q, qr_r, mult_a_new
    );

    modport slave (
        input  qr_start, qr_a, mult_enable, mult_r, mult_q,
        output qr_done, qr_q, qr_r, mult_a_new
    );
endinterface

// File: rtl/qr_iteration_controller.sv
// Sequences the QR eigenvalue loop: decompose A into Q,R, form A' = R*Q, and repeat
// until the subdiagonal falls below EPS or MAX_ITER iterations have completed.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   IDLE     | waiting for start; results of the last run held
//   QR_START | one-cycle qr_start pulse for the current iterate
//   QR_WAIT  | waiting for qr_done; captures Q and R as multiplier operands
//   MUL_RUN  | mult_enable high for MULT_LATENCY+1 cycles; captures R*Q on the last
//   CHECK    | subdiagonal convergence test and iteration limit
//   DONE     | one-cycle done pulse, busy low
module qr_iteration_controller #(
    parameter int unsigned MULT_LATENCY = 6,
    parameter int unsigned MAX_ITER     = 32,
    parameter int unsigned ITER_W       = 6,
    parameter logic [15:0] EPS          = 16'h0010
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [255:0]              in_a,
    output logic                      busy,
    output logic                      done,
    output logic                      converged,
    output logic [ITER_W-1:0]         iter_count,
    output logic [255:0]              out_a,
    qr_iteration_controller_if.master eng
);

    localparam int unsigned CNT_W = (MULT_LATENCY < 1) ? 1 : $clog2(MULT_LATENCY + 1);
    localparam logic [CNT_W-1:0]  CNT_LOAD   = CNT_W'(MULT_LATENCY);
    localparam logic [ITER_W-1:0] ITER_LIMIT = ITER_W'(MAX_ITER);

    typedef enum logic [2:0] {
        IDLE,
        QR_START,
        QR_WAIT,
        MUL_RUN,
        CHECK,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [255:0]     mult_r_q;
    logic [255:0]     mult_q_q;
    logic             conv;
    logic             at_limit;
    logic             mul_last;

    // Signed magnitude of a Q5.10 element; the most negative code has no positive twin.
    function automatic logic [15:0] sat_abs(input logic [15:0] x);
        logic [15:0] neg;
        neg = ~x + 16'd1;
        if (!x[15]) begin
            return x;
        end
        if (x == 16'h8000) begin
            return 16'h7FFF;
        end
        return neg;
    endfunction

    assign conv = (sat_abs(out_a[64 +: 16])  < EPS) &&
                  (sat_abs(out_a[144 +: 16]) < EPS) &&
                  (sat_abs(out_a[224 +: 16]) < EPS);

    assign at_limit = (iter_count == ITER_LIMIT);
    assign mul_last = (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next      = state;
        busy            = 1'b0;
        done            = 1'b0;
        eng.qr_start    = 1'b0;
        eng.mult_enable = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = QR_START;
                end
            end
            QR_START: begin
                busy         = 1'b1;
                eng.qr_start = 1'b1;
                state_next   = QR_WAIT;
            end
            QR_WAIT: begin
                busy = 1'b1;
                if (eng.qr_done) begin
                    state_next = MUL_RUN;
                end
            end
            MUL_RUN: begin
                busy            = 1'b1;
                eng.mult_enable = 1'b1;
                if (mul_last) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                busy = 1'b1;
                if (conv || at_limit) begin
                    state_next = DONE;
                end else begin
                    state_next = QR_START;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The multiplier timer counts down from MULT_LATENCY; terminal count is zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_a      <= '0;
            iter_count <= '0;
            converged  <= 1'b0;
            mult_r_q   <= '0;
            mult_q_q   <= '0;
            cnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        out_a      <= in_a;
                        iter_count <= '0;
                        converged  <= 1'b0;
                    end
                end
                QR_WAIT: begin
                    if (eng.qr_done) begin
                        mult_r_q <= eng.qr_r;
                        mult_q_q <= eng.qr_q;
                        cnt      <= CNT_LOAD;
                    end
                end
                MUL_RUN: begin
                    if (mul_last) begin
                        out_a      <= eng.mult_a_new;
                        iter_count <= iter_count + 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                CHECK: begin
                    if (conv) begin
                        converged <= 1'b1;
                    end else if (at_limit) begin
                        converged <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign eng.qr_a   = out_a;
    assign eng.mult_r = mult_r_q;
    assign eng.mult_q = mult_q_q;

endmodule

// File: tb/tb_qr_iteration_controller.sv
// Bench for qr_iteration_controller: bench-side QR and multiplier models replay a scripted
// sequence of iterates; a run-level model predicts convergence, count, result and timing.
module tb_qr_iteration_controller;

    localparam int L    = 6;
    localparam int MAXI = 32;
    localparam int EPSV = 16;

    logic         clk;
    logic         rst;
    logic         start;
    logic [255:0] in_a;
    logic         busy;
    logic         done;
    logic         converged;
    logic [5:0]   iter_count;
    logic [255:0] out_a;

    qr_iteration_controller_if bus ();

    qr_iteration_controller #(
        .MULT_LATENCY (L),
        .MAX_ITER     (MAXI),
        .ITER_W       (6),
        .EPS          (16'h0010)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_a       (in_a),
        .busy       (busy),
        .done       (done),
        .converged  (converged),
        .iter_count (iter_count),
        .out_a      (out_a),
        .eng        (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_err = 0;

    logic [255:0] iterates [MAXI];
    int           tqr      [MAXI];
    logic [255:0] run_in_a;
    logic [255:0] cur_q;
    logic [255:0] cur_r;
    int           iter_idx;
    int           qr_pulses;
    int           busy_cycles;
    int           done_seen;
    int           rem;
    int           en_cnt;
    bit           prev_qr_start;
    bit           noise;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [15:0] get_el(input logic [255:0] m, input int r, input int c);
        return m[16*(4*r+c) +: 16];
    endfunction

    function automatic logic [255:0] set_el(input logic [255:0] m, input int r, input int c,
                                            input logic [15:0] v);
        logic [255:0] t;
        t = m;
        t[16*(4*r+c) +: 16] = v;
        return t;
    endfunction

    function automatic bit sub_small(input logic [15:0] x);
        int v;
        v = int'($signed(x));
        if (v < 0) v = -v;
        if (v > 32767) v = 32767;
        return v < EPSV;
    endfunction

    function automatic bit is_conv(input logic [255:0] m);
        return sub_small(get_el(m, 1, 0)) && sub_small(get_el(m, 2, 1)) && sub_small(get_el(m, 3, 2));
    endfunction

    function automatic logic [15:0] pick_sub(input bit quiet);
        logic [15:0] big_tbl [8];
        logic [15:0] small_tbl [4];
        int k;
        big_tbl   = '{16'h0000, 16'h000F, 16'hFFF1, 16'h0010, 16'hFFF0, 16'h8000, 16'h0100, 16'h7FFF};
        small_tbl = '{16'h0000, 16'h000F, 16'hFFF1, 16'h0001};
        if (quiet) return small_tbl[$urandom_range(0, 3)];
        k = $urandom_range(0, 8);
        if (k == 8) return 16'($urandom);
        return big_tbl[k];
    endfunction

    function automatic logic [255:0] rand_iter();
        logic [255:0] m;
        bit quiet;
        quiet = ($urandom_range(0, 5) == 0);
        m = rand256();
        m = set_el(m, 1, 0, pick_sub(quiet));
        m = set_el(m, 2, 1, pick_sub(quiet));
        m = set_el(m, 3, 2, pick_sub(quiet));
        return m;
    endfunction

    // One cycle of the engine models: observe outputs mid-cycle, drive this cycle's inputs.
    task automatic model_cycle();
        logic [255:0] exp_qa;
        if (bus.qr_start) begin
            qr_pulses++;
            check("qr_start_width", 256'(prev_qr_start), 256'(0));
            if (iter_idx < MAXI) begin
                exp_qa = (iter_idx == 0) ? run_in_a : iterates[iter_idx-1];
                check("qr_a", bus.qr_a, exp_qa);
                rem = tqr[iter_idx];
            end
        end
        prev_qr_start = bus.qr_start;
        if (busy) busy_cycles++;
        if (done) done_seen++;

        bus.qr_done = 1'b0;
        bus.qr_q    = rand256();
        bus.qr_r    = rand256();
        if (!bus.qr_start && rem > 0) begin
            rem--;
            if (rem == 0) begin
                cur_q       = rand256();
                cur_r       = rand256();
                bus.qr_done = 1'b1;
                bus.qr_q    = cur_q;
                bus.qr_r    = cur_r;
            end
        end

        bus.mult_a_new = rand256();
        if (bus.mult_enable) begin
            en_cnt++;
            check("mult_r", bus.mult_r, cur_r);
            check("mult_q", bus.mult_q, cur_q);
            if (en_cnt == L + 1 && iter_idx < MAXI) begin
                bus.mult_a_new = iterates[iter_idx];
                iter_idx++;
            end
            if (noise && rem == 0 && $urandom_range(0, 2) == 0) bus.qr_done = 1'b1;
        end else if (en_cnt > 0) begin
            check("mult_en_len", 256'(en_cnt), 256'(L + 1));
            en_cnt = 0;
        end

        start = 1'b0;
        if (noise && busy && $urandom_range(0, 3) == 0) start = 1'b1;
        in_a = rand256();
    endtask

    task automatic step();
        @(negedge clk);
        model_cycle();
    endtask

    task automatic begin_run(input logic [255:0] a0, input bit nz);
        noise         = nz;
        run_in_a      = a0;
        iter_idx      = 0;
        qr_pulses     = 0;
        busy_cycles   = 0;
        done_seen     = 0;
        rem           = 0;
        en_cnt        = 0;
        prev_qr_start = 1'b0;
        start         = 1'b1;
        in_a          = a0;
    endtask

    task automatic finish_run(input bit start_in_done);
        int  exp_iters;
        int  exp_busy;
        bit  exp_conv;
        int  t;
        logic [255:0] exp_a;
        exp_iters = MAXI;
        exp_conv  = 1'b0;
        for (int k = 0; k < MAXI; k++) begin
            if (is_conv(iterates[k])) begin
                exp_iters = k + 1;
                exp_conv  = 1'b1;
                break;
            end
        end
        exp_busy = 0;
        for (int k = 0; k < exp_iters; k++) exp_busy += 1 + tqr[k] + (L + 1) + 1;
        exp_a = iterates[exp_iters-1];

        t = 0;
        while (done_seen == 0 && t < 3000) begin
            step();
            t++;
        end
        if (done_seen == 0) begin
            check("done_timeout", 256'(0), 256'(1));
            return;
        end
        check("converged", 256'(converged), 256'(exp_conv));
        check("iter_count", 256'(iter_count), 256'(exp_iters));
        check("out_a", out_a, exp_a);
        check("qr_pulses", 256'(qr_pulses), 256'(exp_iters));
        check("busy_cycles", 256'(busy_cycles), 256'(exp_busy));
        check("busy_in_done", 256'(busy), 256'(0));

        if (start_in_done) begin
            start = 1'b1;
            in_a  = rand256();
        end
        step();
        check("done_width", 256'(done), 256'(0));
        check("busy_after_done", 256'(busy), 256'(0));
        repeat (2) step();
        check("hold_converged", 256'(converged), 256'(exp_conv));
        check("hold_iter_count", 256'(iter_count), 256'(exp_iters));
        check("hold_out_a", out_a, exp_a);
        check("idle_qr_start", 256'(bus.qr_start), 256'(0));
    endtask

    function automatic logic [255:0] diag_a();
        logic [255:0] m;
        m = '0;
        m = set_el(m, 0, 0, 16'h0400);
        m = set_el(m, 1, 1, 16'h0800);
        m = set_el(m, 2, 2, 16'h0C00);
        m = set_el(m, 3, 3, 16'h1000);
        return m;
    endfunction

    task automatic setup_single(input logic [255:0] a0);
        for (int k = 0; k < MAXI; k++) begin
            iterates[k] = a0;
            tqr[k]      = 3;
        end
    endtask

    task automatic setup_no_conv();
        for (int k = 0; k < MAXI; k++) begin
            iterates[k] = set_el(rand256(), 1, 0, 16'h0100);
            tqr[k]      = $urandom_range(1, 4);
        end
    endtask

    task automatic setup_threshold(input logic [15:0] v);
        logic [255:0] m;
        m = set_el(diag_a(), 2, 1, v);
        iterates[0] = m;
        tqr[0]      = $urandom_range(1, 4);
        for (int k = 1; k < MAXI; k++) begin
            iterates[k] = diag_a();
            tqr[k]      = $urandom_range(1, 4);
        end
    endtask

    task automatic setup_random();
        for (int k = 0; k < MAXI; k++) begin
            iterates[k] = rand_iter();
            tqr[k]      = $urandom_range(1, 5);
        end
    endtask

    logic [15:0] thr_vals [4];

    initial begin
        rst           = 1'b1;
        start         = 1'b0;
        in_a          = '0;
        noise         = 1'b0;
        iter_idx      = 0;
        qr_pulses     = 0;
        busy_cycles   = 0;
        done_seen     = 0;
        rem           = 0;
        en_cnt        = 0;
        prev_qr_start = 1'b0;
        cur_q         = '0;
        cur_r         = '0;
        run_in_a      = '0;
        bus.qr_done    = 1'b0;
        bus.qr_q       = '0;
        bus.qr_r       = '0;
        bus.mult_a_new = '0;
        for (int k = 0; k < MAXI; k++) begin
            iterates[k] = '0;
            tqr[k]      = 1;
        end

        repeat (2) step();
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_done", 256'(done), 256'(0));
        check("rst_converged", 256'(converged), 256'(0));
        check("rst_iter_count", 256'(iter_count), 256'(0));
        check("rst_out_a", out_a, 256'(0));
        check("rst_qr_start", 256'(bus.qr_start), 256'(0));
        check("rst_mult_enable", 256'(bus.mult_enable), 256'(0));
        rst = 1'b0;
        step();

        // Q=I, R=A: converges on the first iteration, 12 busy cycles.
        setup_single(diag_a());
        begin_run(diag_a(), 1'b0);
        finish_run(1'b0);

        // Subdiagonal pinned at 0x0100: runs out the iteration limit.
        setup_no_conv();
        begin_run(rand256(), 1'b0);
        finish_run(1'b1);

        thr_vals = '{16'h0010, 16'h000F, 16'hFFF1, 16'h8000};
        for (int i = 0; i < 4; i++) begin
            setup_threshold(thr_vals[i]);
            begin_run(rand256(), 1'b0);
            finish_run(1'b0);
        end

        // Stray start and qr_done while busy must not disturb the run.
        setup_single(diag_a());
        begin_run(diag_a(), 1'b1);
        finish_run(1'b1);
        setup_random();
        begin_run(rand256(), 1'b1);
        finish_run(1'b0);

        // Reset in MUL_RUN with the timer four cycles in.
        setup_no_conv();
        begin_run(rand256(), 1'b0);
        begin
            int t;
            t = 0;
            while (en_cnt != 4 && t < 200) begin
                step();
                t++;
            end
            check("reach_mul_run", 256'(en_cnt), 256'(4));
        end
        rst           = 1'b1;
        rem           = 0;
        en_cnt        = 0;
        iter_idx      = 0;
        prev_qr_start = 1'b0;
        step();
        check("mrst_busy", 256'(busy), 256'(0));
        check("mrst_done", 256'(done), 256'(0));
        check("mrst_converged", 256'(converged), 256'(0));
        check("mrst_iter_count", 256'(iter_count), 256'(0));
        check("mrst_out_a", out_a, 256'(0));
        check("mrst_qr_start", 256'(bus.qr_start), 256'(0));
        check("mrst_mult_enable", 256'(bus.mult_enable), 256'(0));
        check("mrst_mult_r", bus.mult_r, 256'(0));
        check("mrst_mult_q", bus.mult_q, 256'(0));
        rst = 1'b0;
        setup_single(diag_a());
        begin_run(diag_a(), 1'b0);
        finish_run(1'b0);

        for (int r = 0; r < 12; r++) begin
            setup_random();
            begin_run(rand256(), 1'($urandom_range(0, 1)));
            finish_run(1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
